// File: rtl/bsg_manycore_fifo_mem_pkg.sv
// Shared types for the FIFO-side memory responder:
// aligned request/response layouts, opcodes and FSM states.
package bsg_manycore_fifo_mem_pkg;

  localparam logic [31:0] err_data_c = 32'hDEADBEEF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_WRITE,
    ST_RESP
  } state_e;

  typedef enum logic [3:0] {
    OP_LOAD    = 4'd0,
    OP_STORE   = 4'd1,
    OP_AMOSWAP = 4'd2,
    OP_AMOADD  = 4'd3
  } op_e;

  typedef enum logic [1:0] {
    RSP_STORE = 2'd0,
    RSP_LOAD  = 2'd1,
    RSP_AMO   = 2'd2
  } rsp_type_e;

  typedef struct packed {
    logic [23:0] pad;
    logic [7:0]  src_y;
    logic [7:0]  src_x;
    logic [7:0]  reg_id;
    logic [3:0]  rsvd1;
    logic [3:0]  mask;
    logic [3:0]  rsvd0;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic [47:0] pad;
    logic [7:0]  my_y;
    logic [7:0]  my_x;
    logic [7:0]  dst_y;
    logic [7:0]  dst_x;
    logic [5:0]  pad1;
    rsp_type_e   rtype;
    logic [7:0]  reg_id;
    logic [31:0] data;
  } rsp_t;

endpackage

// File: rtl/bsg_manycore_fifo_mem_scratchpad.sv
// Single-port word scratchpad: synchronous read,
// byte-masked write; read data holds until the next read.
module bsg_manycore_fifo_mem_scratchpad #(
  parameter int els_p   = 1024,
  parameter int width_p = 32
) (
  input  logic                     clk_i,
  input  logic                     v_i,
  input  logic                     w_i,
  input  logic [$clog2(els_p)-1:0] addr_i,
  input  logic [width_p-1:0]       data_i,
  input  logic [width_p/8-1:0]     mask_i,
  output logic [width_p-1:0]       data_o
);

  logic [width_p-1:0] mem [els_p];

  always_ff @(posedge clk_i) begin
    if (v_i & w_i) begin
      for (int i = 0; i < width_p/8; i++) begin
        if (mask_i[i]) mem[addr_i][8*i+:8] <= data_i[8*i+:8];
      end
    end
    if (v_i & ~w_i) data_o <= mem[addr_i];
  end

endmodule

// File: rtl/bsg_manycore_fifo_mem_responder.sv
// Memory-mapped manycore target: one request in flight,
// serviced against a local scratchpad, answered on the endpoint.
module bsg_manycore_fifo_mem_responder
  import bsg_manycore_fifo_mem_pkg::*;
#(
  parameter int fifo_width_p   = 128,
  parameter int data_width_p   = 32,
  parameter int addr_width_p   = 32,
  parameter int mem_els_p      = 1024,
  parameter int x_cord_width_p = 8,
  parameter int y_cord_width_p = 8
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [fifo_width_p-1:0]   mc_req_i,
  input  logic                      mc_req_v_i,
  output logic                      mc_req_ready_o,
  output logic [fifo_width_p-1:0]   endpoint_rsp_o,
  output logic                      endpoint_rsp_v_o,
  input  logic                      endpoint_rsp_ready_i,
  input  logic [x_cord_width_p-1:0] my_x_i,
  input  logic [y_cord_width_p-1:0] my_y_i,
  output logic                      busy_o,
  output logic [15:0]               err_count_o
);

  localparam int lg_els_lp = $clog2(mem_els_p);

  state_e state_r, state_n;
  req_t   req;
  rsp_t   rsp;
  logic   accept, legal;

  logic [data_width_p-1:0] data_r;
  logic [lg_els_lp-1:0]    addr_r;
  op_e                     op_r;
  logic [3:0]              mask_r;
  logic [7:0]              reg_id_r, src_x_r, src_y_r;
  logic                    err_r;
  logic [15:0]             err_count_r;

  logic                    mem_v, mem_w;
  logic [data_width_p-1:0] mem_data, wdata;
  logic [3:0]              wmask;
  logic                    unused_bits;

  assign req    = req_t'(mc_req_i);
  assign accept = mc_req_v_i & mc_req_ready_o;
  assign legal  = (addr_width_p'(req.addr) < addr_width_p'(mem_els_p))
                & (req.op < 4'd4);
  assign unused_bits = ^{req.pad, req.rsvd1, req.rsvd0};

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_r <= ST_IDLE;
    else            state_r <= state_n;
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      ST_IDLE: if (mc_req_v_i) begin
        if (!legal)                state_n = ST_RESP;
        else if (req.op == OP_STORE) state_n = ST_WRITE;
        else                       state_n = ST_READ;
      end
      ST_READ:  state_n = (op_r == OP_LOAD) ? ST_RESP : ST_WRITE;
      ST_WRITE: state_n = ST_RESP;
      ST_RESP:  if (endpoint_rsp_ready_i) state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    mc_req_ready_o   = 1'b0;
    endpoint_rsp_v_o = 1'b0;
    busy_o           = 1'b1;
    mem_v            = 1'b0;
    mem_w            = 1'b0;
    unique case (state_r)
      ST_IDLE:  begin mc_req_ready_o = 1'b1; busy_o = 1'b0; end
      ST_READ:  mem_v = 1'b1;
      ST_WRITE: begin mem_v = 1'b1; mem_w = 1'b1; end
      ST_RESP:  endpoint_rsp_v_o = 1'b1;
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      data_r      <= '0;
      addr_r      <= '0;
      op_r        <= OP_LOAD;
      mask_r      <= '0;
      reg_id_r    <= '0;
      src_x_r     <= '0;
      src_y_r     <= '0;
      err_r       <= 1'b0;
      err_count_r <= '0;
    end else if (accept) begin
      data_r   <= req.data;
      addr_r   <= req.addr[lg_els_lp-1:0];
      op_r     <= op_e'(req.op);
      mask_r   <= req.mask;
      reg_id_r <= req.reg_id;
      src_x_r  <= req.src_x;
      src_y_r  <= req.src_y;
      err_r    <= ~legal;
      if (!legal && err_count_r != 16'hFFFF)
        err_count_r <= err_count_r + 16'd1;
    end
  end

  // AMOs write the whole word; only STORE honours the byte mask
  always_comb begin
    wdata = data_r;
    wmask = 4'hF;
    unique case (1'b1)
      op_r == OP_STORE:  wmask = mask_r;
      op_r == OP_AMOADD: wdata = mem_data + data_r;
      default: ;
    endcase
  end

  bsg_manycore_fifo_mem_scratchpad #(
    .els_p   (mem_els_p),
    .width_p (data_width_p)
  ) scratchpad (
    .clk_i  (clk_i),
    .v_i    (mem_v),
    .w_i    (mem_w),
    .addr_i (addr_r),
    .data_i (wdata),
    .mask_i (wmask),
    .data_o (mem_data)
  );

  // payload is forced to zero outside RESP so reset shows a clean bus
  always_comb begin
    rsp = '0;
    if (state_r == ST_RESP) begin
      rsp.reg_id = reg_id_r;
      rsp.dst_x  = src_x_r;
      rsp.dst_y  = src_y_r;
      rsp.my_x   = 8'(my_x_i);
      rsp.my_y   = 8'(my_y_i);
      if (err_r) begin
        rsp.rtype = RSP_STORE;
        rsp.data  = err_data_c;
      end else if (op_r == OP_LOAD) begin
        rsp.rtype = RSP_LOAD;
        rsp.data  = mem_data;
      end else if (op_r == OP_STORE) begin
        rsp.rtype = RSP_STORE;
        rsp.data  = '0;
      end else begin
        rsp.rtype = RSP_AMO;
        rsp.data  = mem_data;
      end
    end
  end

  assign endpoint_rsp_o = fifo_width_p'(rsp);
  assign err_count_o    = err_count_r;

endmodule

// File: tb/tb_bsg_manycore_fifo_mem_responder.sv
// Bench for the FIFO memory responder: directed table,
// hand-built corner sequences and a randomized model check.
module tb_bsg_manycore_fifo_mem_responder;

  localparam int els_lp = 1024;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [127:0] mc_req = '0;
  logic         req_v = 1'b0;
  logic         req_ready;
  logic [127:0] rsp;
  logic         rsp_v;
  logic         rsp_ready = 1'b1;
  logic [7:0]   my_x = 8'hA5;
  logic [7:0]   my_y = 8'h5A;
  logic         busy;
  logic [15:0]  err_count;

  int n_pass = 0;
  int n_total = 0;

  logic [31:0] mdl_mem [int];
  int          mdl_err = 0;

  always #5 clk = ~clk;

  bsg_manycore_fifo_mem_responder dut (
    .clk_i                (clk),
    .reset_n_i            (reset_n),
    .mc_req_i             (mc_req),
    .mc_req_v_i           (req_v),
    .mc_req_ready_o       (req_ready),
    .endpoint_rsp_o       (rsp),
    .endpoint_rsp_v_o     (rsp_v),
    .endpoint_rsp_ready_i (rsp_ready),
    .my_x_i               (my_x),
    .my_y_i               (my_y),
    .busy_o               (busy),
    .err_count_o          (err_count)
  );

  task automatic check(input string name,
                       input logic [135:0] act,
                       input logic [135:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // reference: response type/data/latency from the op rules
  function automatic void model(input logic [3:0] op,
                                input logic [31:0] a, d,
                                input logic [3:0] m,
                                output logic [1:0] t,
                                output logic [31:0] rd,
                                output int lat);
    logic [31:0] old;
    if (a >= 32'(els_lp) || op > 4'd3) begin
      t = 2'd0; rd = 32'hDEADBEEF; lat = 1;
      if (mdl_err < 65535) mdl_err++;
      return;
    end
    old = mdl_mem.exists(int'(a)) ? mdl_mem[int'(a)] : 32'h0;
    case (op)
      4'd0: begin t = 2'd1; rd = old; lat = 2; end
      4'd1: begin
        t = 2'd0; rd = 32'h0; lat = 2;
        for (int b = 0; b < 4; b++)
          if (m[b]) old[8*b+:8] = d[8*b+:8];
        mdl_mem[int'(a)] = old;
      end
      4'd2: begin t = 2'd2; rd = old; lat = 3; mdl_mem[int'(a)] = d; end
      default: begin
        t = 2'd2; rd = old; lat = 3; mdl_mem[int'(a)] = old + d;
      end
    endcase
  endfunction

  function automatic logic [127:0] pack_req(input logic [3:0] op,
                                            input logic [31:0] a, d,
                                            input logic [3:0] m,
                                            input logic [7:0] rid, sx, sy);
    logic [127:0] p;
    p = {$urandom, $urandom, $urandom, $urandom};
    p[31:0]   = d;
    p[63:32]  = a;
    p[67:64]  = op;
    p[75:72]  = m;
    p[87:80]  = rid;
    p[95:88]  = sx;
    p[103:96] = sy;
    return p;
  endfunction

  task automatic txn(input string name,
                     input logic [3:0] op,
                     input logic [31:0] a, d,
                     input logic [3:0] m,
                     input logic [1:0] et,
                     input logic [31:0] ed,
                     input int el, input int ee, input int stall);
    logic [7:0]   rid, sx, sy;
    logic [127:0] exp, cap;
    int           lat;
    bit           seen;
    rid = 8'($urandom); sx = 8'($urandom); sy = 8'($urandom);
    @(posedge clk); #1;
    mc_req = pack_req(op, a, d, m, rid, sx, sy);
    req_v = 1'b1;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    req_v = 1'b0;
    lat = 0; seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (rsp_v) seen = 1;
    end
    exp = {48'h0, my_y, my_x, sy, sx, 6'h0, et, rid, ed};
    check({name, " latency"}, 136'(lat), 136'(el));
    check({name, " rsp"}, 136'(rsp), 136'(exp));
    if (!seen) begin rsp_ready = 1'b1; return; end
    cap = rsp;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); @(negedge clk);
      check({name, " hold"}, {6'h0, rsp_v, req_ready, rsp},
            {6'h0, 1'b1, 1'b0, cap});
    end
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check({name, " post"}, 136'({rsp_v, req_ready, busy, err_count}),
          136'({1'b0, 1'b1, 1'b0, 16'(ee)}));
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
    logic [1:0]  et;
    logic [31:0] ed;
    int          lat;
    int          err;
  } vec_t;

  vec_t vt [13];

  initial begin
    logic [1:0]  t;
    logic [31:0] rd, a, d;
    logic [3:0]  op, m;
    int          lat, stall;
    logic [1:0]  b2b [6];

    vt[0]  = '{4'd1, 32'd5, 32'h1234_5678, 4'hF, 2'd0, 32'h0, 2, 0};
    vt[1]  = '{4'd0, 32'd5, 32'h0, 4'h0, 2'd1, 32'h1234_5678, 2, 0};
    vt[2]  = '{4'd1, 32'd5, 32'hAABB_CCDD, 4'h3, 2'd0, 32'h0, 2, 0};
    vt[3]  = '{4'd0, 32'd5, 32'h0, 4'h0, 2'd1, 32'h1234_CCDD, 2, 0};
    vt[4]  = '{4'd1, 32'd5, 32'hFFFF_FFFF, 4'hF, 2'd0, 32'h0, 2, 0};
    vt[5]  = '{4'd3, 32'd5, 32'h1, 4'h0, 2'd2, 32'hFFFF_FFFF, 3, 0};
    vt[6]  = '{4'd0, 32'd5, 32'h0, 4'h0, 2'd1, 32'h0, 2, 0};
    vt[7]  = '{4'd0, 32'(els_lp), 32'h0, 4'h0, 2'd0, 32'hDEADBEEF, 1, 1};
    vt[8]  = '{4'd7, 32'd5, 32'h99, 4'hF, 2'd0, 32'hDEADBEEF, 1, 2};
    vt[9]  = '{4'd0, 32'd5, 32'h0, 4'h0, 2'd1, 32'h0, 2, 2};
    vt[10] = '{4'd2, 32'd5, 32'h55, 4'h1, 2'd2, 32'h0, 3, 2};
    vt[11] = '{4'd0, 32'd5, 32'h0, 4'h0, 2'd1, 32'h55, 2, 2};
    vt[12] = '{4'd1, 32'h8000_0005, 32'h1, 4'hF, 2'd0, 32'hDEADBEEF, 1, 3};

    repeat (3) @(posedge clk);
    #1;
    check("in reset", 136'({rsp_v, busy, err_count, rsp}), 136'(0));
    reset_n = 1'b1;
    @(negedge clk);
    check("after reset", 136'({req_ready, rsp_v, busy, err_count, rsp}),
          136'({1'b1, 1'b0, 1'b0, 16'h0, 128'h0}));

    foreach (vt[i]) begin
      model(vt[i].op, vt[i].addr, vt[i].data, vt[i].mask, t, rd, lat);
      txn($sformatf("vec%0d", i), vt[i].op, vt[i].addr, vt[i].data,
          vt[i].mask, vt[i].et, vt[i].ed, vt[i].lat, vt[i].err, 0);
    end

    txn("stall10", 4'd0, 32'd5, 32'h0, 4'h0, 2'd1, 32'h55, 2, 3, 10);

    b2b[0] = 2'b00; b2b[1] = 2'b10; b2b[2] = 2'b01;
    b2b[3] = 2'b00; b2b[4] = 2'b10; b2b[5] = 2'b01;
    @(posedge clk); #1;
    mc_req = pack_req(4'd0, 32'd5, 32'h0, 4'h0, 8'h11, 8'h22, 8'h33);
    req_v = 1'b1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("b2b cyc%0d", i), 136'({rsp_v, req_ready}),
            136'(b2b[i]));
      if (i == 4)
        check("b2b data", 136'(rsp[31:0]), 136'(32'h55));
      if (i == 2) begin
        @(posedge clk); #1;
        req_v = 1'b0;
      end
    end

    @(posedge clk); #1;
    mc_req = pack_req(4'd3, 32'd5, 32'h1, 4'hF, 8'h1, 8'h2, 8'h3);
    req_v = 1'b1;
    @(posedge clk); #1;
    req_v = 1'b0;
    @(negedge clk);
    check("amo busy", 136'({busy, rsp_v}), 136'(2'b10));
    reset_n = 1'b0;
    #1;
    check("mid reset", 136'({rsp_v, busy, err_count, rsp}), 136'(0));
    mdl_err = 0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("released", 136'({req_ready, rsp_v}), 136'(2'b10));
    txn("load after reset", 4'd0, 32'd5, 32'h0, 4'h0, 2'd1, 32'h55, 2, 0, 0);

    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      model(4'd1, 32'(i), d, 4'hF, t, rd, lat);
      txn($sformatf("init%0d", i), 4'd1, 32'(i), d, 4'hF, t, rd, lat,
          mdl_err, 0);
    end

    for (int i = 0; i < 150; i++) begin
      int r;
      r = $urandom_range(0, 9);
      op = 4'($urandom_range(0, 3));
      a = 32'($urandom_range(0, 15));
      if (r == 0) a = ($urandom & 1) ? 32'(els_lp) + $urandom_range(0, 4095)
                                    : ($urandom | 32'h8000_0000);
      if (r == 1) op = 4'($urandom_range(4, 15));
      d = $urandom;
      m = 4'($urandom);
      stall = $urandom_range(0, 2);
      model(op, a, d, m, t, rd, lat);
      txn($sformatf("rnd%0d", i), op, a, d, m, t, rd, lat, mdl_err, stall);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
